fb_scanout: RTL and testbench
=============================

# fb_scanout

Framebuffer scanout engine for the Flippy Bit DE0 build. It reads the 1200-bit framebuffer produced by the display renderer and generates 640x480@60 VGA timing from CLOCK_50. Each framebuffer bit is shown as a 16x16-pixel cell on a 40x30 grid. It drives the red/green/blue/sync wires of the top level and tells the game logic when a frame starts and when vertical blanking is active.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- FG_COLOR, 12'hFFF, {R,G,B} colour for a set bit
- BG_COLOR, 12'h000, {R,G,B} colour for a clear bit

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, rising edge
- reset_button  in  1  asynchronous, active-low reset
- framebuffer  in  1200  cell bits; index = row*40 + col; bit 0 is top-left, bit 39 is top-right
- red_out  out  4  red
- green_out  out  4  green
- blue_out  out  4  blue
- h_sync_out  out  1  horizontal sync, active low
- v_sync_out  out  1  vertical sync, active low
- frame_start  out  1  one-CLOCK_50-cycle pulse when the counters wrap to (0,0)
- vblank  out  1  high while v_count >= V_VISIBLE

## Operation
- pix_en is an internal toggle register: reset 0, inverts every CLOCK_50 edge, giving a 25 MHz pixel enable.
- h_count runs 0..H_TOTAL-1, where H_TOTAL = 800. It advances on edges where pix_en = 1.
- v_count runs 0..V_TOTAL-1, where V_TOTAL = 525. It advances when h_count wraps.
- When v_count is at V_TOTAL-1 and h_count wraps, both counters go to 0.
- Cell lookup:
  - col = h_count[9:4], row = v_count[9:4]
  - idx = (row<<5) + (row<<3) + col, 11 bits, maximum 1199
  - No multiplier is used.
- Visible region is h_count < 640 and v_count < 480:
  - RGB = FG_COLOR if the bit at idx is set, otherwise BG_COLOR.
- Outside the visible region RGB is forced to 0, and idx is never used.
- h_sync_out is low for h_count in [656, 751].
- v_sync_out is low for v_count in [490, 491].
- frame_start is asserted for exactly the one CLOCK_50 cycle after the wrap edge.
- All outputs are registered.
- Reset values:
  - red_out, green_out, blue_out = 0
  - h_sync_out = 1, v_sync_out = 1
  - frame_start = 0, vblank = 0
  - h_count = 0, v_count = 0, pix_en = 0

## Timing
- On each pix_en edge, all outputs are updated from the pre-increment (h_count, v_count). RGB and both syncs are therefore cycle-aligned, with one pixel period of latency from counter to pin.
- Outputs hold their values for 2 CLOCK_50 cycles, one pixel period.
- Line period is 1600 CLOCK_50 cycles. Frame period is 840000 CLOCK_50 cycles.
- Reset assertion is asynchronous: all registers take their reset values immediately, with no wait for a clock edge, including mid-line and mid-sync.
- After reset release:
  - first edge sets pix_en = 1;
  - second edge produces the output for (0,0) and advances h_count to 1.
- framebuffer changes have no handshake. How they are sampled is set by the configuration below.

## Configuration
- FB_SNAPSHOT_EN defined:
  - A 1200-bit shadow register is reset to all zeros.
  - It loads from framebuffer on the pix_en edge where v_count goes 479 to 480 (start of vblank).
  - Cell lookup reads the shadow, so a displayed frame never tears.
  - Until the first load the screen shows BG_COLOR.
- FB_SNAPSHOT_EN undefined:
  - Cell lookup reads framebuffer live.
  - Changes appear at the next pixel sampled; tearing is permitted.

## Test plan
- Release reset, framebuffer = 0:
  - h_sync_out low for exactly 192 CLOCK_50 cycles, with falling edges every 1600 cycles;
  - v_sync_out low for 3200 cycles, with falling edges every 840000 cycles;
  - frame_start pulses are 1 cycle wide and 840000 cycles apart.
- Only framebuffer bit 0 set (with FB_SNAPSHOT_EN, after one vblank):
  - RGB = 12'hFFF for x 0..15, y 0..15;
  - RGB = 0 everywhere else.
- Only bit 1199 set:
  - white only for x 624..639, y 464..479.
- All bits set:
  - RGB = 0 at every sample with h_count >= 640 or v_count >= 480;
  - vblank is high exactly for lines 480..524.
- With FB_SNAPSHOT_EN, change framebuffer from 0 to all ones at v_count = 100:
  - current frame remains black;
  - next frame is white from line 0.
- Without the macro, the same change turns the screen white from line 100 onward.
- Assert reset_button low at h_count = 300, v_count = 200, mid-visible:
  - outputs go to reset values in the same cycle, before any clock edge;
  - after release, timing restarts from (0,0), with the first h_sync fall 1312 cycles after the (0,0) output.

Source files
------------

// File: rtl/fb_scanout.sv
// VGA 640x480@60 scanout of a 40x30 grid of 16x16-pixel cells from a 1200-bit framebuffer.
// Define FB_SNAPSHOT_EN to latch the framebuffer once per frame at the start of vblank (tear-free).
`timescale 1ns/1ps
module fb_scanout #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic          CLOCK_50,
  input  logic          reset_button,
  input  logic [1199:0] framebuffer,
  output logic [3:0]    red_out,
  output logic [3:0]    green_out,
  output logic [3:0]    blue_out,
  output logic          h_sync_out,
  output logic          v_sync_out,
  output logic          frame_start,
  output logic          vblank
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] C_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] C_V_LOAD     = 10'(V_VISIBLE - 1);
  localparam logic [9:0] C_HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] C_HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] C_VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] C_VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic          r_pix_en;
  logic [9:0]    r_h_count;
  logic [9:0]    r_v_count;
  logic [11:0]   r_rgb;
  logic          r_h_sync;
  logic          r_v_sync;
  logic          r_frame_start;
  logic          r_vblank;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_visible;
  logic [5:0]    w_col;
  logic [5:0]    w_row;
  logic [10:0]   w_idx;
  logic [10:0]   w_cell_idx;
  logic [1199:0] w_fb_src;
  logic          w_cell_on;
  logic [11:0]   w_rgb;
  logic          w_h_sync;
  logic          w_v_sync;
  logic          w_vblank;

  assign w_h_last  = (r_h_count == C_H_LAST);
  assign w_v_last  = (r_v_count == C_V_LAST);
  assign w_visible = (r_h_count < C_H_VIS) && (r_v_count < C_V_VIS);

  // row*40 + col built from two shifts so no multiplier is inferred
  assign w_col      = r_h_count[9:4];
  assign w_row      = r_v_count[9:4];
  assign w_idx      = ({5'd0, w_row} << 5) + ({5'd0, w_row} << 3) + {5'd0, w_col};
  assign w_cell_idx = w_visible ? w_idx : 11'd0;
  assign w_cell_on  = w_visible && w_fb_src[w_cell_idx];

  assign w_rgb    = !w_visible ? 12'h000 : (w_cell_on ? FG_COLOR : BG_COLOR);
  assign w_h_sync = !((r_h_count >= C_HS_FIRST) && (r_h_count <= C_HS_LAST));
  assign w_v_sync = !((r_v_count >= C_VS_FIRST) && (r_v_count <= C_VS_LAST));
  assign w_vblank = (r_v_count >= C_V_VIS);

`ifdef FB_SNAPSHOT_EN
  logic [1199:0] r_fb_shadow;

  always_ff @(posedge CLOCK_50 or negedge reset_button) begin
    if (!reset_button) begin
      r_fb_shadow <= '0;
    end else if (r_pix_en && w_h_last && (r_v_count == C_V_LOAD)) begin
      r_fb_shadow <= framebuffer;
    end
  end

  assign w_fb_src = r_fb_shadow;
`else
  assign w_fb_src = framebuffer;
`endif

  // Outputs are built from the pre-increment counters, so RGB and syncs stay aligned
  always_ff @(posedge CLOCK_50 or negedge reset_button) begin
    if (!reset_button) begin
      r_pix_en      <= 1'b0;
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_rgb         <= '0;
      r_h_sync      <= 1'b1;
      r_v_sync      <= 1'b1;
      r_frame_start <= 1'b0;
      r_vblank      <= 1'b0;
    end else begin
      r_pix_en      <= ~r_pix_en;
      r_frame_start <= 1'b0;
      if (r_pix_en) begin
        r_rgb    <= w_rgb;
        r_h_sync <= w_h_sync;
        r_v_sync <= w_v_sync;
        r_vblank <= w_vblank;
        if (w_h_last) begin
          r_h_count <= '0;
          if (w_v_last) begin
            r_v_count     <= '0;
            r_frame_start <= 1'b1;
          end else begin
            r_v_count <= r_v_count + 10'd1;
          end
        end else begin
          r_h_count <= r_h_count + 10'd1;
        end
      end
    end
  end

  assign red_out     = r_rgb[11:8];
  assign green_out   = r_rgb[7:4];
  assign blue_out    = r_rgb[3:0];
  assign h_sync_out  = r_h_sync;
  assign v_sync_out  = r_v_sync;
  assign frame_start = r_frame_start;
  assign vblank      = r_vblank;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a shrunken-timing instance for whole-frame behaviour and a full 640x480 instance.
`timescale 1ns/1ps
module tb_fb_scanout;

  localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVV = 48, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;
  localparam int SN  = SHT * SVT;
  localparam int FHV = 640, FHF = 16, FHS = 96, FHB = 48;
  localparam int FVV = 480, FVF = 10, FVS = 2, FVB = 33;
  localparam int FHT = FHV + FHF + FHS + FHB;
  localparam int FVT = FVV + FVF + FVS + FVB;
  localparam int FN  = FHT * FVT;
  localparam logic [14:0] RST_OUT = {12'h000, 1'b1, 1'b1, 1'b0};
`ifdef FB_SNAPSHOT_EN
  localparam logic [11:0] WHT = 12'h000;
`else
  localparam logic [11:0] WHT = 12'hFFF;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1199:0] fb_s = '0;
  logic [1199:0] fb_f = '0;
  logic [3:0]    s_r, s_g, s_b, f_r, f_g, f_b;
  logic          s_hs, s_vs, s_fs, s_vb, f_hs, f_vs, f_fs, f_vb;
  logic [14:0]   s_out, f_out;
  int            n_checks = 0;
  int            n_fail = 0;
  int            fs_count = 0;
  int            ti = 0;

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
    logic        hs;
  } vec_t;
  vec_t tbl[20];

  always #10 clk = ~clk;

  assign s_out = {s_r, s_g, s_b, s_hs, s_vs, s_vb};
  assign f_out = {f_r, f_g, f_b, f_hs, f_vs, f_vb};

  fb_scanout #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .CLOCK_50(clk), .reset_button(rst_n), .framebuffer(fb_s),
    .red_out(s_r), .green_out(s_g), .blue_out(s_b),
    .h_sync_out(s_hs), .v_sync_out(s_vs), .frame_start(s_fs), .vblank(s_vb)
  );

  fb_scanout u_full (
    .CLOCK_50(clk), .reset_button(rst_n), .framebuffer(fb_f),
    .red_out(f_r), .green_out(f_g), .blue_out(f_b),
    .h_sync_out(f_hs), .v_sync_out(f_vs), .frame_start(f_fs), .vblank(f_vb)
  );

  // Reference: what the pins show for pixel (h,v) given the cell bits in effect
  function automatic logic [14:0] ref_out(input int h, input int v, input int hv, input int hf,
                                          input int hs, input int vv, input int vf, input int vs,
                                          input logic [1199:0] fb);
    logic [11:0] rgb;
    logic        hsn, vsn, vb;
    rgb = 12'h000;
    if (h < hv && v < vv && fb[(v / 16) * 40 + h / 16]) rgb = 12'hFFF;
    hsn = !(h >= hv + hf && h < hv + hf + hs);
    vsn = !(v >= vv + vf && v < vv + vf + vs);
    vb  = (v >= vv);
    return {rgb, hsn, vsn, vb};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  task automatic randomize_fb();
    for (int i = 0; i < 1200; i++) fb_s[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_phase(input int ncyc, input bit stim);
    logic [14:0]   exp_s, exp_f;
    logic [1199:0] sh_s, sh_f;
    logic          prev_f_hs, prev_s_vs;
    int            f_hs_last, s_vs_last, s_fs_last, f_hs_falls, s_vs_falls;
    int            n, h, v, kk;
    exp_s = RST_OUT; exp_f = RST_OUT;
    sh_s = '0; sh_f = '0;
    prev_f_hs = 1'b1; prev_s_vs = 1'b1;
    f_hs_last = 0; s_vs_last = 0; s_fs_last = -1; f_hs_falls = 0; s_vs_falls = 0;
    chk("s_release", 0, 32'(s_out), 32'(RST_OUT));
    chk("f_release", 0, 32'(f_out), 32'(RST_OUT));
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k >= 2 && k % 2 == 0) begin
        n = (k - 2) / 2;
        h = n % SHT; v = (n / SHT) % SVT;
`ifdef FB_SNAPSHOT_EN
        exp_s = ref_out(h, v, SHV, SHF, SHS, SVV, SVF, SVS, sh_s);
        if (h == SHT - 1 && v == SVV - 1) sh_s = fb_s;
`else
        exp_s = ref_out(h, v, SHV, SHF, SHS, SVV, SVF, SVS, fb_s);
`endif
        h = n % FHT; v = (n / FHT) % FVT;
`ifdef FB_SNAPSHOT_EN
        exp_f = ref_out(h, v, FHV, FHF, FHS, FVV, FVF, FVS, sh_f);
        if (h == FHT - 1 && v == FVV - 1) sh_f = fb_f;
`else
        exp_f = ref_out(h, v, FHV, FHF, FHS, FVV, FVF, FVS, fb_f);
`endif
      end
      chk("s_out", k, 32'(s_out), 32'(exp_s));
      chk("s_fs", k, 32'(s_fs), 32'(k % (2 * SN) == 0));
      chk("f_out", k, 32'(f_out), 32'(exp_f));
      chk("f_fs", k, 32'(f_fs), 32'(k % (2 * FN) == 0));

      if (stim && ti < 20) begin
        kk = 2 + 2 * (tbl[ti].v * FHT + tbl[ti].h);
        if (k == kk) begin
          chk("tbl_rgb", k, 32'({f_r, f_g, f_b}), 32'(tbl[ti].rgb));
          chk("tbl_hs", k, 32'(f_hs), 32'(tbl[ti].hs));
          ti++;
        end
      end

      if (prev_f_hs && !f_hs) begin
        if (f_hs_falls == 0) chk("hs_first_fall", k, 32'(k - 2), 32'd1312);
        else chk("hs_period", k, 32'(k - f_hs_last), 32'd1600);
        f_hs_falls++;
        f_hs_last = k;
      end
      if (!prev_f_hs && f_hs) chk("hs_width", k, 32'(k - f_hs_last), 32'd192);
      prev_f_hs = f_hs;

      if (prev_s_vs && !s_vs) begin
        if (s_vs_falls > 0) chk("vs_period", k, 32'(k - s_vs_last), 32'(2 * SN));
        s_vs_falls++;
        s_vs_last = k;
      end
      if (!prev_s_vs && s_vs) chk("vs_width", k, 32'(k - s_vs_last), 32'(2 * SVS * SHT));
      prev_s_vs = s_vs;

      if (s_fs) begin
        if (s_fs_last >= 0) chk("fs_period", k, 32'(k - s_fs_last), 32'(2 * SN));
        s_fs_last = k;
        fs_count++;
      end

      if (stim) begin
        if (k == 3200) fb_s = '1;
        if (k == 12000) randomize_fb();
        if (k > 14000 && $urandom_range(0, 499) == 0) randomize_fb();
        if (k == 15990) fb_f = '1;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{0,   0,  WHT,     1'b1};
    tbl[1]  = '{15,  0,  WHT,     1'b1};
    tbl[2]  = '{16,  0,  12'h000, 1'b1};
    tbl[3]  = '{639, 0,  12'h000, 1'b1};
    tbl[4]  = '{640, 0,  12'h000, 1'b1};
    tbl[5]  = '{655, 0,  12'h000, 1'b1};
    tbl[6]  = '{656, 0,  12'h000, 1'b0};
    tbl[7]  = '{751, 0,  12'h000, 1'b0};
    tbl[8]  = '{752, 0,  12'h000, 1'b1};
    tbl[9]  = '{0,   1,  WHT,     1'b1};
    tbl[10] = '{15,  9,  WHT,     1'b1};
    tbl[11] = '{16,  9,  12'h000, 1'b1};
    tbl[12] = '{300, 9,  12'h000, 1'b1};
    tbl[13] = '{0,   10, WHT,     1'b1};
    tbl[14] = '{639, 10, WHT,     1'b1};
    tbl[15] = '{640, 10, 12'h000, 1'b1};
    tbl[16] = '{15,  15, WHT,     1'b1};
    tbl[17] = '{0,   16, WHT,     1'b1};
    tbl[18] = '{650, 16, 12'h000, 1'b1};
    tbl[19] = '{700, 16, 12'h000, 1'b0};

    fb_f = 1200'(1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("s_in_reset", 0, 32'({s_out, s_fs}), 32'({RST_OUT, 1'b0}));
    chk("f_in_reset", 0, 32'({f_out, f_fs}), 32'({RST_OUT, 1'b0}));
    rst_n = 1'b1;
    run_phase(30000, 1'b1);
    chk("tbl_done", 0, 32'(ti), 32'd20);
    chk("fs_count_p1", 0, 32'(fs_count), 32'd3);

    // Mid-line reset: outputs must clear before the next clock edge
    fb_s = '1;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #2;
    chk("s_async_rst", 0, 32'({s_out, s_fs}), 32'({RST_OUT, 1'b0}));
    chk("f_async_rst", 0, 32'({f_out, f_fs}), 32'({RST_OUT, 1'b0}));
    repeat (2) @(negedge clk);
    chk("s_rst_hold", 0, 32'({s_out, s_fs}), 32'({RST_OUT, 1'b0}));
    rst_n = 1'b1;
    fs_count = 0;
    run_phase(10000, 1'b0);
    chk("fs_count_p2", 0, 32'(fs_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
